// File: rtl/feature_linebuffer.sv
// Purpose : gathers a serial 32-bit feature stream into the 41-entry inner-product window.
// Latency : xarray_valid rises 1 clk after the sample that completes the window.
// Backpr. : din_ready drops for the whole time a window is held; xarray_ready=0 holds it indefinitely.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   din/_valid/_sof    sample stream in; din_sof (qualified by din_valid) restarts the count
//   din_ready          high while collecting samples (state only, no path from inputs)
//   xarray[0:40]       window out: [0]=BIAS, [1]=0, [2]=oldest .. [40]=newest sample
//   xarray_valid/ready window handshake to the inner-product stage
module feature_linebuffer #(
  parameter int unsigned NFEAT  = 39,
  parameter int unsigned STRIDE = 39,
  parameter logic [31:0] BIAS   = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        din_valid,
  input  logic        din_sof,
  output logic        din_ready,
  output logic [31:0] xarray [0:40],
  output logic        xarray_valid,
  input  logic        xarray_ready
);

  localparam logic [5:0] NFEAT_C  = 6'(NFEAT);
  // Samples already in the window that count toward the next one after a handshake.
  localparam logic [5:0] RESUME_C = 6'(NFEAT - STRIDE);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [5:0]  count_inc;
  logic [31:0] win_q [2:40];
  logic [31:0] win_d [2:40];
  logic        accept;

  assign accept    = din_valid && (state_q == FILL);
  // A start-of-frame sample abandons the partial window: it becomes sample #1.
  assign count_inc = din_sof ? 6'd1 : (count_q + 6'd1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    win_d   = win_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          // Old entries always shift, even across a frame restart.
          for (int k = 2; k < 40; k++) begin
            win_d[k] = win_q[k+1];
          end
          win_d[40] = din;
          count_d   = count_inc;
          if (count_inc == NFEAT_C) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Window contents are kept so overlapping samples are reused.
        if (xarray_ready) begin
          state_d = FILL;
          count_d = RESUME_C;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= 6'd0;
      for (int k = 2; k <= 40; k++) begin
        win_q[k] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      win_q   <= win_d;
    end
  end

  assign din_ready    = (state_q == FILL);
  assign xarray_valid = (state_q == HOLD);

  always_comb begin
    xarray[0] = BIAS;
    xarray[1] = 32'd0;
    for (int k = 2; k <= 40; k++) begin
      xarray[k] = win_q[k];
    end
  end

endmodule

// File: tb/tb_feature_linebuffer.sv
// Bench for feature_linebuffer: two instances (STRIDE=4 and STRIDE=39) share one
// input stream, each with its own xarray_ready, and are compared every cycle
// against a window model kept as plain arrays of samples.
module tb_feature_linebuffer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic        din_sof;
  logic        rdy0, rdy1;
  logic        xv0, xv1;
  logic        xr0, xr1;
  logic [31:0] xa0 [0:40];
  logic [31:0] xa1 [0:40];

  feature_linebuffer #(.STRIDE(4)) dut_s4 (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .din_sof      (din_sof),
    .din_ready    (rdy0),
    .xarray       (xa0),
    .xarray_valid (xv0),
    .xarray_ready (xr0)
  );

  feature_linebuffer dut_s39 (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .din_sof      (din_sof),
    .din_ready    (rdy1),
    .xarray       (xa1),
    .xarray_valid (xv1),
    .xarray_ready (xr1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: per instance, the 39 most recent samples (index 2 oldest),
  // the number of samples counted toward the current window, and whether
  // a window is being held for the consumer.
  logic [31:0] mw [2][2:40];
  int          mc [2];
  bit          mh [2];
  int          stride_of [2] = '{4, 39};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_x(input int i, input int k);
    return (i == 0) ? xa0[k] : xa1[k];
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mh[i] = 1'b0;
        mc[i] = 0;
        for (int k = 2; k <= 40; k++) mw[i][k] = 32'd0;
      end else if (!mh[i]) begin
        if (din_valid) begin
          for (int k = 2; k < 40; k++) mw[i][k] = mw[i][k+1];
          mw[i][40] = din;
          mc[i] = din_sof ? 1 : mc[i] + 1;
          if (mc[i] == 39) mh[i] = 1'b1;
        end
      end else if ((i == 0) ? xr0 : xr1) begin
        mh[i] = 1'b0;
        mc[i] = 39 - stride_of[i];
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      int          bad_k;
      logic [31:0] exp_v;
      chk($sformatf("s%0d_xarray_valid", stride_of[i]), (i == 0) ? xv0 : xv1, mh[i]);
      chk($sformatf("s%0d_din_ready", stride_of[i]), (i == 0) ? rdy0 : rdy1, !mh[i]);
      bad_k = 0;
      for (int k = 40; k >= 0; k--) begin
        exp_v = (k == 0) ? 32'd1 : (k == 1) ? 32'd0 : mw[i][k];
        if (dut_x(i, k) !== exp_v) bad_k = k;
      end
      exp_v = (bad_k == 0) ? 32'd1 : (bad_k == 1) ? 32'd0 : mw[i][bad_k];
      chk($sformatf("s%0d_xarray[%0d]", stride_of[i], bad_k), dut_x(i, bad_k), exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  initial begin
    rst = 1'b1; din = 32'd0; din_valid = 1'b0; din_sof = 1'b0;
    xr0 = 1'b0; xr1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mh[i] = 1'b0; mc[i] = 0;
      for (int k = 2; k <= 40; k++) mw[i][k] = 32'd0;
    end
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("t1_valid", xv0, 0);
    chk("t1_ready", rdy0, 1);
    chk("t1_x0", xa0[0], 32'd1);
    chk("t1_x1", xa0[1], 32'd0);
    chk("t1_x2", xa0[2], 32'd0);
    chk("t1_x40", xa1[40], 32'd0);

    // Fill a window with 1..39, no gaps
    din_valid = 1'b1;
    for (int v = 1; v <= 39; v++) begin
      din = v;
      tick();
      if (v == 38) chk("t2_not_yet_valid", xv0, 0);
    end
    din_valid = 1'b0;
    chk("t2_valid", xv0, 1);
    chk("t2_valid_s39", xv1, 1);
    chk("t2_x2", xa0[2], 32'd1);
    chk("t2_x40", xa0[40], 32'd39);
    chk("t2_ready", rdy0, 0);
    chk("t2_model_x40", mw[0][40], 32'd39);
    chk("t2_model_x21", mw[1][21], 32'd20);

    // Hold with consumer stalled while samples are offered
    din_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      din = 1000 + j;
      tick();
    end
    din_valid = 1'b0;
    chk("t3_valid", xv0, 1);
    chk("t3_x2", xa0[2], 32'd1);
    chk("t3_x40", xa0[40], 32'd39);
    chk("t3_ready", rdy1, 0);

    // Handshake, then slide by 4 on the STRIDE=4 instance
    xr0 = 1'b1; xr1 = 1'b1;
    tick();
    xr0 = 1'b0; xr1 = 1'b0;
    chk("t4_ready_after_hs", rdy0, 1);
    chk("t4_valid_after_hs", xv0, 0);
    din_valid = 1'b1;
    for (int v = 40; v <= 43; v++) begin
      din = v;
      tick();
      if (v == 42) chk("t4_not_yet_valid", xv0, 0);
    end
    din_valid = 1'b0;
    chk("t4_valid", xv0, 1);
    chk("t4_x2", xa0[2], 32'd5);
    chk("t4_x40", xa0[40], 32'd43);
    chk("t4_s39_still_filling", xv1, 0);
    chk("t4_s39_x2", xa1[2], 32'd5);
    chk("t4_model_cnt_s39", mc[1], 4);

    // Reset while holding
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", xv0, 0);
    chk("t6_x2", xa0[2], 32'd0);
    chk("t6_x40", xa0[40], 32'd0);
    chk("t6_ready", rdy0, 1);
    chk("t6_model_cnt", mc[0], 0);

    // Frame restart mid-window
    din_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      din = 500 + j;
      tick();
    end
    din = 100; din_sof = 1'b1;
    tick();
    din_sof = 1'b0;
    for (int v = 101; v <= 138; v++) begin
      din = v;
      tick();
      if (v == 137) chk("t5_not_yet_valid", xv0, 0);
    end
    din_valid = 1'b0;
    chk("t5_valid", xv0, 1);
    chk("t5_x2", xa0[2], 32'd100);
    chk("t5_x40", xa0[40], 32'd138);
    chk("t5_valid_s39", xv1, 1);
    chk("t5_s39_x2", xa1[2], 32'd100);

    xr0 = 1'b1; xr1 = 1'b1;
    tick();

    // Randomized traffic, stalls, frame restarts and occasional resets
    for (int c = 0; c < 3000; c++) begin
      din       = $urandom;
      din_valid = ($urandom_range(0, 3) != 0);
      din_sof   = ($urandom_range(0, 19) == 0);
      xr0       = ($urandom_range(0, 2) != 0);
      xr1       = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; din_valid = 1'b0; din_sof = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
